debug_latch_reader: RTL



---
 rtl/debug_pkg.sv | 62 ++++++
 rtl/word_serializer.sv | 50 +++++
 rtl/debug_latch_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the pipeline debug latch mux and its reader.
// Holds the reader FSM state type, the select-code constants (shared with the mux) and the
// ordered select table the reader walks through on every dump.
package debug_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StWait,
    StLoad,
    StSend,
    StNext,
    StFin
  } dbg_state_e;

  localparam int unsigned DBG_NUM_SEL = 20;
  localparam int unsigned DBG_IDX_W   = 5;

  // Fetch stage latches
  localparam logic [6:0] SelIf0  = 7'h00;
  localparam logic [6:0] SelIf1  = 7'h01;
  // Decode stage latches
  localparam logic [6:0] SelId0  = 7'h10;
  localparam logic [6:0] SelId1  = 7'h11;
  localparam logic [6:0] SelId3  = 7'h13;
  localparam logic [6:0] SelId4  = 7'h14;
  localparam logic [6:0] SelId5  = 7'h15;
  localparam logic [6:0] SelId6  = 7'h16;
  // Execute stage latches
  localparam logic [6:0] SelEx0  = 7'h20;
  localparam logic [6:0] SelEx1  = 7'h21;
  localparam logic [6:0] SelEx3  = 7'h23;
  localparam logic [6:0] SelEx4  = 7'h24;
  localparam logic [6:0] SelEx5  = 7'h25;
  // Memory stage latches
  localparam logic [6:0] SelMem0 = 7'h30;
  localparam logic [6:0] SelMem1 = 7'h31;
  localparam logic [6:0] SelMem2 = 7'h32;
  localparam logic [6:0] SelMem3 = 7'h33;
  localparam logic [6:0] SelMem4 = 7'h34;
  // Write-back stage latches
  localparam logic [6:0] SelWb0  = 7'h40;
  localparam logic [6:0] SelWb1  = 7'h41;

  // Dump order; entry 0 goes out first.
  localparam logic [6:0] DBG_SEL_TABLE [DBG_NUM_SEL] = '{
    SelIf0, SelIf1,
    SelId0, SelId1, SelId3, SelId4, SelId5, SelId6,
    SelEx0, SelEx1, SelEx3, SelEx4, SelEx5,
    SelMem0, SelMem1, SelMem2, SelMem3, SelMem4,
    SelWb0, SelWb1
  };

  // Out-of-range indices fall back to a defined code: the mux floats on undefined ones.
  function automatic logic [6:0] dbg_sel_code(input logic [DBG_IDX_W-1:0] idx);
    if (idx < DBG_IDX_W'(DBG_NUM_SEL)) begin
      return DBG_SEL_TABLE[idx];
    end
    return SelIf0;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits a 32-bit word into four bytes, most significant byte first, with valid/ready flow.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load_i    - capture word_i and start presenting bytes (only asserted while idle)
//   word_i    - word to serialize
//   ready_i   - sink accepts the current byte this cycle
//   byte_o    - current byte (top of the shift register)
//   valid_o   - byte_o is valid; held until accepted
//   last_o    - the fourth byte of the word is being accepted this cycle
module word_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [31:0] shreg_q;
  logic [1:0]  cnt_q;
  logic        valid_q;
  logic        accept;

  assign accept = valid_q & ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shreg_q <= word_i;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (accept) begin
      shreg_q <= {shreg_q[23:0], 8'h00};
      cnt_q   <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign byte_o  = shreg_q[31:24];
  assign valid_o = valid_q;
  assign last_o  = accept & (cnt_q == 2'd3);

endmodule

// File: rtl/debug_latch_reader.sv
// Reader side of the pipeline debug latch mux. On start it walks every defined select code,
// waits for the registered mux output to settle, captures the word and streams it to the
// debug UART TX as four bytes MSB first, optionally preceded by a frame header byte.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   start     - one-cycle dump request (ignored while busy or during the done cycle)
//   mux_data  - word returned by the latch mux
//   tx_ready  - UART TX accepts tx_data this cycle
//   mux_sel   - select code driven to the latch mux
//   tx_data   - byte to the UART TX
//   tx_valid  - tx_data valid, held stable until accepted
//   busy      - dump in progress
//   done      - one-cycle pulse after the last byte is accepted
module debug_latch_reader
  import debug_pkg::*;
#(
  parameter int unsigned SEL_LATENCY = 2,
  parameter bit          SEND_HEADER = 1'b1,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mux_data,
  input  logic        tx_ready,
  output logic [6:0]  mux_sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0]           LatLast = 8'(SEL_LATENCY - 1);
  localparam logic [DBG_IDX_W-1:0] LastIdx = DBG_IDX_W'(DBG_NUM_SEL - 1);

  dbg_state_e           state_q;
  logic [6:0]           mux_sel_q;
  logic [DBG_IDX_W-1:0] idx_q;
  logic [7:0]           lat_cnt_q;
  logic                 hdr_valid_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 ser_load;
  logic [7:0]           ser_byte;
  logic                 ser_valid;
  logic                 ser_last;

  assign ser_load = (state_q == StLoad);

  word_serializer u_word_serializer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .word_i  (mux_data),
    .ready_i (tx_ready),
    .byte_o  (ser_byte),
    .valid_o (ser_valid),
    .last_o  (ser_last)
  );

  // lat_cnt_q counts cycles since mux_sel last changed; HDR cycles count toward the settle
  // time, so the counter saturates there and WAIT may fall straight through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mux_sel_q   <= SelIf0;
      idx_q       <= '0;
      lat_cnt_q   <= '0;
      hdr_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            busy_q    <= 1'b1;
            idx_q     <= '0;
            mux_sel_q <= dbg_sel_code('0);
            lat_cnt_q <= '0;
            if (SEND_HEADER) begin
              hdr_valid_q <= 1'b1;
              state_q     <= StHdr;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StHdr: begin
          if (lat_cnt_q != LatLast) begin
            lat_cnt_q <= lat_cnt_q + 8'd1;
          end
          if (tx_ready) begin
            hdr_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (lat_cnt_q == LatLast) begin
            state_q <= StLoad;
          end else begin
            lat_cnt_q <= lat_cnt_q + 8'd1;
          end
        end
        StLoad: begin
          state_q <= StSend;
        end
        StSend: begin
          if (ser_last) begin
            state_q <= StNext;
          end
        end
        StNext: begin
          if (idx_q == LastIdx) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFin;
          end else begin
            idx_q     <= idx_q + 1'b1;
            mux_sel_q <= dbg_sel_code(idx_q + 1'b1);
            lat_cnt_q <= '0;
            state_q   <= StWait;
          end
        end
        StFin: begin
          // start is deliberately not sampled here
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mux_sel  = mux_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_valid = hdr_valid_q | ser_valid;
  assign tx_data  = hdr_valid_q ? HEADER_BYTE : ser_byte;

endmodule
